// File: rtl/prog_mem_loader.sv
// Byte-stream program-memory loader: parses a length-prefixed frame and emits 14-bit instruction writes.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_mem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [13:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = S_CHK;
`else
  localparam state_t FINAL_STATE = S_DONE;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  len_hi_reg;
  logic [11:0] count_reg;
  logic [11:0] idx_reg;
  logic [5:0]  hi_reg;
  logic        wr_en_reg;
  logic [10:0] wr_addr_reg;
  logic [13:0] wr_data_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  sum_reg;
`endif

  logic        accept;
  logic        can_start;
  logic [11:0] len_word;
  logic        last_word;

  assign in_ready  = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                     (state_reg == S_DATA_HI) || (state_reg == S_DATA_LO) ||
                     (state_reg == S_CHK);
  assign accept    = in_ready && in_valid;
  assign can_start = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR);
  assign len_word  = {len_hi_reg[3:0], in_data};
  assign last_word = ((idx_reg + 12'd1) == count_reg);

  // rst gates the strobe combinationally so a write already registered is never seen.
  assign wr_en    = wr_en_reg & ~rst;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign done     = (state_reg == S_DONE);
  assign err      = (state_reg == S_ERR);
  assign cpu_hold = !((state_reg == S_IDLE) || (state_reg == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ((len_hi_reg[7:4] != 4'd0) || (len_word > 12'd2048)) state_next = S_ERR;
          else if (len_word == 12'd0)                              state_next = FINAL_STATE;
          else                                                     state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) state_next = (in_data[7:6] != 2'd0) ? S_ERR : S_DATA_LO;
      end
      S_DATA_LO: begin
        if (accept) state_next = last_word ? FINAL_STATE : S_DATA_HI;
      end
      S_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept) state_next = (in_data == sum_reg) ? S_DONE : S_ERR;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_reg  <= 8'd0;
      count_reg   <= 12'd0;
      idx_reg     <= 12'd0;
      hi_reg      <= 6'd0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 11'd0;
      wr_data_reg <= 14'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_reg     <= 8'd0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      if (can_start && start) begin
        idx_reg <= 12'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_reg <= 8'd0;
`endif
      end
      if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_reg <= sum_reg + in_data;
`endif
        case (state_reg)
          S_LEN_HI:  len_hi_reg <= in_data;
          S_LEN_LO:  count_reg  <= len_word;
          S_DATA_HI: hi_reg     <= in_data[5:0];
          S_DATA_LO: begin
            // A word is only committed once both halves are in; errors occur before this point.
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= idx_reg[10:0];
            wr_data_reg <= {hi_reg, in_data};
            idx_reg     <= idx_reg + 12'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed self-checking bench for prog_mem_loader; writes are logged at the falling edge.
// Checksum scenarios are compiled in when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [13:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [10:0] log_addr[$];
  logic [13:0] log_data[$];

  prog_mem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      $display("write addr %0d data %04h", wr_addr, wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    checks++; if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== 30'd0) begin errors++; $display("FAIL reset_outputs got rdy%b we%b a%h d%h h%b dn%b er%b want all 0", in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err); end
    start = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, cpu_hold} !== 2'b00) begin errors++; $display("FAIL reset_priority got rdy%b hold%b want 0 0", in_ready, cpu_hold); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    send(8'h00); send(8'h02); send(8'h30); send(8'h04); send(8'h00); send(8'hA5);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_final_wr_en got %b want 1", wr_en); end
    checks++; if (wr_addr !== 11'd1) begin errors++; $display("FAIL basic_final_addr got %0d want 1", wr_addr); end
    checks++; if (wr_data !== 14'h00A5) begin errors++; $display("FAIL basic_final_data got %h want 00a5", wr_data); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_cpu_hold got %b want 0", cpu_hold); end
    tick();
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_strobe_one_cycle got %b want 0", wr_en); end
    checks++; if ({wr_addr, wr_data} !== {11'd1, 14'h00A5}) begin errors++; $display("FAIL basic_hold_values got %h/%h want 1/00a5", wr_addr, wr_data); end
    checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL basic_write_count got %0d want 2", log_addr.size()); end
    else begin
      checks++; if ({log_addr[0], log_data[0]} !== {11'd0, 14'h3004}) begin errors++; $display("FAIL basic_word0 got %h/%h want 0/3004", log_addr[0], log_data[0]); end
      checks++; if ({log_addr[1], log_data[1]} !== {11'd1, 14'h00A5}) begin errors++; $display("FAIL basic_word1 got %h/%h want 1/00a5", log_addr[1], log_data[1]); end
    end
    $display("test_basic done");
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    send(8'h00); send(8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready got %b want 0", in_ready); end
    tick(); tick();
    @(negedge clk);
    checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", log_addr.size()); end
    $display("test_zero_len done");
  endtask

  task automatic test_bad_len();
    clear_log();
    pulse_start();
    send(8'h08); send(8'h01);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({err, cpu_hold, in_ready, done} !== 4'b1100) begin errors++; $display("FAIL badlen_status got err%b hold%b rdy%b done%b want 1 1 0 0", err, cpu_hold, in_ready, done); end
    pulse_start();
    @(negedge clk);
    checks++; if ({in_ready, err} !== 2'b10) begin errors++; $display("FAIL badlen_restart got rdy%b err%b want 1 0", in_ready, err); end
    send(8'h10); send(8'h01);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badlen_hi_nibble got err%b want 1", err); end
    checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL badlen_writes got %0d want 0", log_addr.size()); end
    $display("test_bad_len done");
  endtask

  task automatic test_bad_data();
    clear_log();
    pulse_start();
    send(8'h00); send(8'h01);
    in_valid = 1'b0;
    pulse_start();
    send(8'h40); send(8'h00);
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL baddata_err got %b want 1", err); end
    checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL baddata_writes got %0d want 0", log_addr.size()); end
    $display("test_bad_data done");
  endtask

  task automatic test_max_len();
    pulse_start();
    send(8'h08); send(8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({err, in_ready} !== 2'b01) begin errors++; $display("FAIL maxlen_accept got err%b rdy%b want 0 1", err, in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("test_max_len done");
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send(8'h00); send(8'h05);
    send(8'h11); send(8'h11); send(8'h12); send(8'h22);
    send(8'h13); send(8'h33); send(8'h14); send(8'h44);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL resetmid_suppress got %b want 0", wr_en); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== 30'd0) begin errors++; $display("FAIL resetmid_outputs got rdy%b we%b a%h d%h h%b dn%b er%b want all 0", in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err); end
    checks++; if (log_addr.size() !== 3) begin errors++; $display("FAIL resetmid_writes got %0d want 3", log_addr.size()); end
    else begin
      checks++; if ({log_addr[2], log_data[2]} !== {11'd2, 14'h1333}) begin errors++; $display("FAIL resetmid_word2 got %h/%h want 2/1333", log_addr[2], log_data[2]); end
    end
    $display("test_reset_mid done");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    pulse_start();
    send(8'h00); send(8'h01); send(8'h28); send(8'h10); send(8'h39);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL chk_good_done got %b want 1", done); end
    checks++; if (log_addr.size() !== 1 || log_data[0] !== 14'h2810) begin errors++; $display("FAIL chk_good_write got n%0d want 1 write of 2810", log_addr.size()); end
    clear_log();
    pulse_start();
    send(8'h00); send(8'h01); send(8'h28); send(8'h10); send(8'h3A);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_bad_err got %b want 1", err); end
    checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL chk_bad_write got %0d want 1", log_addr.size()); end
    $display("test_checksum done");
  endtask
`else
  task automatic test_no_checksum();
    clear_log();
    pulse_start();
    send(8'h00); send(8'h01); send(8'h28); send(8'h10);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({done, in_ready, wr_en} !== 3'b101) begin errors++; $display("FAIL nochk_done got dn%b rdy%b we%b want 1 0 1", done, in_ready, wr_en); end
    checks++; if (wr_data !== 14'h2810) begin errors++; $display("FAIL nochk_data got %h want 2810", wr_data); end
    $display("test_no_checksum done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_bad_len();
    test_bad_data();
    test_max_len();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_no_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-005 in_data  input  8  download byte.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts a byte; transfer occurs when in_valid and in_ready are both high on a clk edge.
REQ-008 wr_en  output  1  one-cycle program-memory write strobe.
REQ-009 wr_addr  output  11  program-memory word address.
REQ-010 wr_data  output  14  instruction word to write.
REQ-011 cpu_hold  output  1  holds the CPU in reset while a load is in progress or has failed.
REQ-012 done  output  1  load completed successfully.
REQ-013 err  output  1  load aborted on a frame error.

Function
REQ-014 Frame format SHALL be: LEN_HI, LEN_LO, then per word DATA_HI, DATA_LO, then optionally CHK (see REQ-032).
REQ-015 Word count SHALL be {LEN_HI[3:0], LEN_LO}, 12 bits; LEN_HI[7:4] SHALL be nonzero-checked as an error.
REQ-016 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR.
REQ-017 IDLE/DONE/ERR --start--> LEN_HI; start in any other state SHALL be ignored.
REQ-018 in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK; state advances only on an accepted byte.
REQ-019 LEN_LO accepted: count 0 -> DONE (no writes); count > 2048 or LEN_HI[7:4] != 0 -> ERR; else -> DATA_HI.
REQ-020 DATA_HI accepted: byte[7:6] != 0 -> ERR; else latch byte[5:0] as wr_data[13:8], -> DATA_LO.
REQ-021 DATA_LO accepted: on the next cycle wr_en = 1 for exactly one cycle, wr_data = {hi[5:0], byte}, wr_addr = current word index.
REQ-022 Word index SHALL start at 0 on each start, increment by 1 after each write, and never wrap (max index 2047).
REQ-023 After the last DATA_LO: -> DONE (or CHK when configured); otherwise -> DATA_HI.
REQ-024 done SHALL be 1 only in DONE, rising in the same cycle as the final wr_en; err SHALL be 1 only in ERR.
REQ-025 cpu_hold SHALL be 1 in every state except IDLE and DONE.
REQ-026 wr_addr and wr_data SHALL hold their last values when wr_en = 0.
REQ-027 Entering ERR SHALL never produce a write for the partial word in progress.
REQ-028 Back-to-back bytes (in_valid held high) SHALL be accepted at one byte per cycle with no bubbles.

Reset
REQ-029 rst SHALL force IDLE, word index 0, and in_ready, wr_en, done, err, cpu_hold to 0, and wr_addr, wr_data to 0.
REQ-030 rst mid-frame SHALL abandon the frame with no further writes; a pending wr_en SHALL be suppressed.
REQ-031 rst SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-032 With PROG_LOADER_CHECKSUM_EN defined, after the last data word the block SHALL enter CHK and accept one byte; match with the modulo-256 sum of all preceding frame bytes -> DONE, mismatch -> ERR (words already written remain written); count-0 frames SHALL also pass through CHK.
REQ-033 Without PROG_LOADER_CHECKSUM_EN, CHK SHALL be unreachable and no checksum byte SHALL be consumed.

Verification
REQ-034 start; bytes 00 02 30 04 00 A5 -> wr_en at addr 0 data 0x3004, addr 1 data 0x00A5; done=1, cpu_hold=0.
REQ-035 start; bytes 00 00 -> no wr_en; done=1 the cycle after LEN_LO accepted.
REQ-036 start; bytes 08 01 -> err=1, cpu_hold=1, in_ready=0, no writes; start again -> LEN_HI.
REQ-037 start; bytes 00 01 40 00 -> err=1, no write.
REQ-038 Checksum build: bytes 00 01 28 10 39 -> write addr 0 data 0x2810, done=1; last byte 3A instead -> err=1 after the write.
REQ-039 rst asserted on the cycle after DATA_LO of word 3 of a 5-word frame -> no wr_en for word 3, all outputs 0 next cycle.
